// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: owns the PC, reads memory, hands the IR downstream
// Optional fetch_count statistics port is built only when FETCH_STATS_EN is defined.
module instruction_fetch_unit #(
  parameter int unsigned MEM_DEPTH   = 16384,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [15:0] mem_data,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc_out
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [15:0] PC_LAST   = 16'(MEM_DEPTH - 1);
  localparam logic [2:0]  WAIT_INIT = 3'(MEM_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept;
  logic [15:0] jump_target;
  logic [15:0] pc_next;

  assign accept      = valid_q & instr_ready;
  assign jump_target = 16'(32'(jump_addr) % MEM_DEPTH);
  assign pc_next     = (pc_q == PC_LAST) ? 16'd0 : pc_q + 16'd1;

  // A jump overrides every state; leaving WAIT via jump drops the pending read.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (jump) begin
      pc_d    = jump_target;
      valid_d = 1'b0;
      state_d = S_ISSUE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ISSUE;
        S_ISSUE: begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            ir_d    = mem_data;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_HOLD: begin
          if (accept) begin
            valid_d = 1'b0;
            pc_d    = pc_next;
            state_d = S_ISSUE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= 16'd0;
      ir_q    <= 16'd0;
      valid_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count_q <= 16'd0;
    end else if (accept && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  assign mem_addr    = pc_q;
  assign mem_rd_en   = (state_q == S_ISSUE);
  assign instr_out   = ir_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed bench with a timeline model of the fetch stage
module tb_instruction_fetch_unit;
  localparam int DEPTH = 16384;
  localparam int LAT   = 1;

  logic        clk;
  logic        reset;
  logic        jump;
  logic [15:0] jump_addr;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_data;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_out;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count;
`endif

  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .jump(jump),
    .jump_addr(jump_addr),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_data(mem_data),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_out(pc_out)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  logic [15:0] mem [0:DEPTH-1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered single-cycle read memory
  always @(posedge clk) mem_data <= mem[mem_addr[13:0]];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          t_issue  = 0;
  bit          model_on = 0;
  logic [15:0] m_pc     = 16'd0;
  logic        exp_valid;
  int          m_cnt    = 0;

  int          lit_kind  = 0;
  logic [15:0] lit_instr = 16'd0;
  logic [15:0] lit_pc    = 16'd0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a fetch issues at t_issue and its word is visible from t_issue+LAT+1
  // until consumed; accepts and jumps restart the timeline on the next cycle.
  initial begin
    forever begin
      @(negedge clk);
      exp_valid = 1'b0;
      if (model_on) begin
        exp_valid = (cyc >= t_issue + LAT + 1);
        check("pc_out", pc_out, m_pc);
        check("mem_addr", mem_addr, m_pc);
        check("mem_rd_en", {15'd0, mem_rd_en}, {15'd0, cyc == t_issue});
        check("instr_valid", {15'd0, instr_valid}, {15'd0, exp_valid});
        if (exp_valid) check("instr_out", instr_out, mem[m_pc[13:0]]);
`ifdef FETCH_STATS_EN
        check("fetch_count", fetch_count, 16'(m_cnt));
`endif
      end
      case (lit_kind)
        1: begin
          check("lit_valid", {15'd0, instr_valid}, 16'd1);
          check("lit_instr", instr_out, lit_instr);
          check("lit_pc", pc_out, lit_pc);
        end
        2: begin
          check("rst_valid", {15'd0, instr_valid}, 16'd0);
          check("rst_pc", pc_out, 16'd0);
          check("rst_instr", instr_out, 16'd0);
          check("rst_rd_en", {15'd0, mem_rd_en}, 16'd0);
`ifdef FETCH_STATS_EN
          check("rst_count", fetch_count, 16'd0);
`endif
        end
        3: begin
`ifdef FETCH_STATS_EN
          check("lit_count", fetch_count, lit_instr);
`endif
        end
        5: begin
          check("lit_issue", {15'd0, mem_rd_en}, 16'd1);
          check("lit_addr", mem_addr, lit_pc);
        end
        default: ;
      endcase
      if (!reset) begin
        model_on = 1;
        m_pc     = 16'd0;
        t_issue  = cyc + 2;
        m_cnt    = 0;
      end else if (model_on) begin
        if (exp_valid && instr_ready && m_cnt != 65535) m_cnt++;
        if (jump) begin
          m_pc    = 16'(int'(jump_addr) % DEPTH);
          t_issue = cyc + 1;
        end else if (exp_valid && instr_ready) begin
          m_pc    = (int'(m_pc) == DEPTH - 1) ? 16'd0 : m_pc + 16'd1;
          t_issue = cyc + 1;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input int k, input logic [15:0] ei, input logic [15:0] ep);
    lit_kind  = k;
    lit_instr = ei;
    lit_pc    = ep;
    @(negedge clk);
    #1;
    lit_kind = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i * 273) ^ 16'h5A5A;
    mem[0]        = 16'h1234;
    mem[1]        = 16'hABCD;
    mem[2]        = 16'hC0DE;
    mem[3]        = 16'hD00D;
    mem[16'h0040] = 16'h4040;
    mem[16'h0041] = 16'h4141;
    mem[16'h3FFF] = 16'hBEEF;
    reset       = 1'b0;
    jump        = 1'b0;
    jump_addr   = 16'd0;
    instr_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;                          // c0
    lit(2, 16'd0, 16'd0);                  // c0 reset state
    lit(5, 16'd0, 16'd0);                  // c1 issue addr 0
    tick();
    lit(1, 16'h1234, 16'd0);               // c3 first delivery
    tick(); tick();
    lit(1, 16'hABCD, 16'd1);               // c6
    tick(); tick();
    lit(1, 16'hC0DE, 16'd2);               // c9
    tick(); tick();
    instr_ready = 1'b0;                    // c12
    lit(1, 16'hD00D, 16'd3);
    repeat (4) tick();
    lit(1, 16'hD00D, 16'd3);               // c17 still held
    instr_ready = 1'b1;                    // c18 accept
    tick();
    lit(5, 16'd0, 16'd4);                  // c19 issue pc+1
    jump = 1'b1; jump_addr = 16'h0040;     // c20 jump during WAIT
    tick();
    jump = 1'b0;
    tick(); tick();
    lit(1, 16'h4040, 16'h0040);            // c23
    jump = 1'b1; jump_addr = 16'h3FFF;     // c24
    tick();
    jump = 1'b0;
    tick(); tick();
    lit(1, 16'hBEEF, 16'h3FFF);            // c27
    lit(5, 16'd0, 16'd0);                  // c28 wrapped to 0
    tick();
    jump = 1'b1; jump_addr = 16'h4041;     // c30 jump with accept, out of range
    tick();
    jump = 1'b0;
    lit(5, 16'd0, 16'h0041);               // c31
    tick();
    instr_ready = 1'b0;                    // c33
    lit(1, 16'h4141, 16'h0041);
    reset = 1'b0;                          // c34 reset while holding
`ifdef FETCH_STATS_EN
    lit(3, 16'd7, 16'd0);
`else
    tick();
`endif
    lit(2, 16'd0, 16'd0);                  // c35
    reset = 1'b1;                          // c36
    instr_ready = 1'b1;
    repeat (10) tick();
`ifdef FETCH_STATS_EN
    lit(3, 16'd3, 16'd0);                  // c46
`else
    tick();
`endif
    reset = 1'b0;
    tick();
    lit(2, 16'd0, 16'd0);
    reset = 1'b1;
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
